// File: rtl/multicycle_alu.sv
// multicycle_alu: one-hot-selected ALU. mul/div iterate over BITS cycles; every other op finishes in one.
// Define MULTICYCLE_ALU_DIV_EN to build the signed restoring divider; without it div decodes as illegal.
module multicycle_alu #(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [11:0]       ctrl_signal,
  input  logic [BITS-1:0]   X,
  input  logic [BITS-1:0]   Y,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] result,
  output logic              div_by_zero,
  output logic              illegal_op
);

  localparam int              SW     = $clog2(BITS);
  localparam int              CW     = $clog2(BITS + 1);
  localparam logic [BITS-1:0] MOD    = BITS'(BITS);
  localparam logic [CW-1:0]   LAST   = CW'(BITS);
  localparam int              OP_MUL = 2;
  localparam int              OP_DIV = 3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nxt;

  logic              one_hot, legal, is_mul, is_div, div_zero, accept, go_exec;
  logic [BITS-1:0]   mag_x, mag_y;
  logic [SW-1:0]     amt;
  logic [2*BITS-1:0] x2;
  logic [BITS-1:0]   op_val;

  // Shared iterative datapath: {hi, lo} is the partial product, or {remainder, quotient}.
  logic [BITS-1:0]   hi, lo, opnd;
  logic [CW-1:0]     cnt;
  logic              sx, sy;
  logic [BITS:0]     m_sum;
  logic [BITS-1:0]   step_hi, step_lo;
  logic [2*BITS-1:0] prod, fin_res;

  assign one_hot  = (ctrl_signal != '0) && ((ctrl_signal & (ctrl_signal - 12'd1)) == '0);
  assign is_mul   = one_hot && ctrl_signal[OP_MUL];
  assign accept   = start && (state != EXEC);
  assign div_zero = is_div && (Y == '0);
  assign go_exec  = is_mul || (is_div && !div_zero);
  assign mag_x    = X[BITS-1] ? '0 - X : X;
  assign mag_y    = Y[BITS-1] ? '0 - Y : Y;

  always_comb begin
    amt    = SW'(Y % MOD);
    x2     = {X, X};
    op_val = '0;
    case (ctrl_signal)
      12'h001: op_val = X + Y;
      12'h002: op_val = X - Y;
      12'h010: op_val = X >> amt;
      12'h020: op_val = X << amt;
      12'h040: op_val = BITS'(x2 >> amt);
      // Rotate left by amt is rotate right by BITS-amt; amt=0 shifts by BITS and still yields X.
      12'h080: op_val = BITS'(x2 >> (MOD - BITS'(amt)));
      12'h100: op_val = X & Y;
      12'h200: op_val = X | Y;
      12'h400: op_val = '0 - X;
      12'h800: op_val = ~X;
      default: op_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nxt = go_exec ? EXEC : DONE;
        else       state_nxt = IDLE;
      end
      EXEC: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  logic          op_div;
  logic [BITS:0] d_shift, d_diff;
  logic [BITS-1:0] quo, rem;

  assign is_div = one_hot && ctrl_signal[OP_DIV];
  assign legal  = one_hot;

  always_ff @(posedge clk) begin
    if (clr)         op_div <= 1'b0;
    else if (accept) op_div <= is_div;
  end

  // Remainder stays below |Y| <= 2^(BITS-1), so the shifted trial value always fits in BITS+1 bits.
  assign d_shift = {hi, lo[BITS-1]};
  assign d_diff  = d_shift - {1'b0, opnd};
  assign quo     = (sx ^ sy) ? '0 - lo : lo;
  assign rem     = sx ? '0 - hi : hi;
`else
  assign is_div = 1'b0;
  assign legal  = one_hot && !ctrl_signal[OP_DIV];
`endif

  always_comb begin
    m_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    step_hi = m_sum[BITS:1];
    step_lo = {m_sum[0], lo[BITS-1:1]};
    prod    = {hi, lo};
    fin_res = (sx ^ sy) ? '0 - prod : prod;
`ifdef MULTICYCLE_ALU_DIV_EN
    if (op_div) begin
      step_hi = d_diff[BITS] ? d_shift[BITS-1:0] : d_diff[BITS-1:0];
      step_lo = {lo[BITS-2:0], ~d_diff[BITS]};
      fin_res = {rem, quo};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      cnt         <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
    end else if (accept) begin
      div_by_zero <= div_zero;
      illegal_op  <= !legal;
      hi          <= '0;
      lo          <= mag_x;
      opnd        <= mag_y;
      sx          <= X[BITS-1];
      sy          <= Y[BITS-1];
      cnt         <= '0;
      if (!go_exec) result <= div_zero ? {X, {BITS{1'b1}}} : {{BITS{1'b0}}, op_val};
    end else if (state == EXEC) begin
      // BITS iteration cycles, then one cycle to apply the sign and publish the result.
      if (cnt != LAST) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt + 1'b1;
      end else begin
        result <= fin_res;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors; the stimulus side queues expected results and a monitor
// compares them whenever done pulses. Div vectors follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;

  localparam int BITS = 32;
  localparam logic [11:0] C_ADD = 12'h001, C_SUB = 12'h002, C_MUL = 12'h004, C_DIV = 12'h008;
  localparam logic [11:0] C_SHR = 12'h010, C_SHL = 12'h020, C_ROR = 12'h040, C_ROL = 12'h080;
  localparam logic [11:0] C_AND = 12'h100, C_OR  = 12'h200, C_NEG = 12'h400, C_NOT = 12'h800;

  logic              clk = 1'b0;
  logic              clr, start;
  logic [11:0]       ctrl_signal;
  logic [BITS-1:0]   X, Y;
  logic              busy, done, div_by_zero, illegal_op;
  logic [2*BITS-1:0] result;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        dbz;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.BITS(BITS)) dut (
    .clk(clk), .clr(clr), .start(start), .ctrl_signal(ctrl_signal), .X(X), .Y(Y),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding, result=%h", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result, mon_e.res);
        check({mon_e.name, "_div_by_zero"}, 64'(div_by_zero), 64'(mon_e.dbz));
        check({mon_e.name, "_illegal_op"}, 64'(illegal_op), 64'(mon_e.ill));
      end
    end
  end

  // Call at a negedge; start is then sampled at the next posedge (edge N).
  task automatic issue(input string name, input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] res, input logic dbz, input logic ill);
    exp_t e;
    e.name = name; e.res = res; e.dbz = dbz; e.ill = ill;
    sb.push_back(e);
    ctrl_signal = c; X = x; Y = y; start = 1'b1;
  endtask

  // lat = negedges after edge N's negedge until done is seen; busy must be high on each of them.
  task automatic run_op(input string name, input logic [11:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] res, input logic dbz, input logic ill, input int lat);
    int n;
    int busy_cnt;
    issue(name, c, x, y, res, dbz, ill);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    @(negedge clk);
    check({name, "_result_held"}, result, res);
    check({name, "_flags_held"}, {61'd0, done, div_by_zero, illegal_op}, {61'd0, 1'b0, dbz, ill});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int done_seen;
    clr = 1'b1; start = 1'b0; ctrl_signal = '0; X = '0; Y = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {result, 59'd0, busy, done, div_by_zero, illegal_op, 1'b0}, '0);
    check("reset_result", result, 64'd0);
    clr = 1'b0;
    @(negedge clk);

    run_op("add",     C_ADD, 32'd7,         32'd5,          64'h0000_0000_0000_000C, 1'b0, 1'b0, 0);
    run_op("sub",     C_SUB, 32'd5,         32'd7,          64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 0);
    run_op("mul",     C_MUL, 32'hFFFF_FFFD, 32'd7,          64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 33);
    run_op("mul_min", C_MUL, 32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0, 1'b0, 33);
`ifdef MULTICYCLE_ALU_DIV_EN
    run_op("div",      C_DIV, 32'd17,        32'hFFFF_FFFB, {32'h0000_0002, 32'hFFFF_FFFD}, 1'b0, 1'b0, 33);
    run_op("div_negx", C_DIV, 32'hFFFF_FFEF, 32'd5,         {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0, 1'b0, 33);
    run_op("div_min",  C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0, 1'b0, 33);
    run_op("div_zero", C_DIV, 32'd9,         32'd0,         {32'h0000_0009, 32'hFFFF_FFFF}, 1'b1, 1'b0, 0);
`else
    run_op("div_off",      C_DIV, 32'd17, 32'hFFFF_FFFB, 64'd0, 1'b0, 1'b1, 0);
    run_op("div_off_zero", C_DIV, 32'd9,  32'd0,         64'd0, 1'b0, 1'b1, 0);
`endif
    run_op("ror",     C_ROR, 32'h8000_0001, 32'd33, 64'h0000_0000_C000_0000, 1'b0, 1'b0, 0);
    run_op("rol",     C_ROL, 32'h8000_0001, 32'd4,  64'h0000_0000_0000_0018, 1'b0, 1'b0, 0);
    run_op("shr",     C_SHR, 32'h8000_0000, 32'd31, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0);
    run_op("shl_amt0", C_SHL, 32'h0000_0001, 32'd32, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0);
    run_op("and",     C_AND, 32'h0000_F0F0, 32'h0000_FF00, 64'h0000_0000_0000_F000, 1'b0, 1'b0, 0);
    run_op("or",      C_OR,  32'h0000_000F, 32'h0000_00F0, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, 0);
    run_op("neg",     C_NEG, 32'd5,         32'd0,  64'h0000_0000_FFFF_FFFB, 1'b0, 1'b0, 0);
    run_op("not",     C_NOT, 32'd0,         32'd0,  64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 0);

    // clr during the 10th EXEC cycle of a mul: everything clears and no done follows.
    issue("mul_abort", C_MUL, 32'd5, 32'd6, 64'd30, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before_clr", 64'(busy), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    void'(sb.pop_back());
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    run_op("illegal_two_hot", 12'h003, 32'd7, 32'd5, 64'd0, 1'b0, 1'b1, 0);
    run_op("illegal_zero",    12'h000, 32'd7, 32'd5, 64'd0, 1'b0, 1'b1, 0);

    // start pulsed mid-EXEC is ignored: latency unchanged and exactly one done.
    issue("mul_ignore", C_MUL, 32'd12, 32'd12, 64'h0000_0000_0000_0090, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ctrl_signal = C_ADD; X = 32'd1; Y = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 5;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ignore_latency", 64'(n), 64'd33);
    @(negedge clk);
    check("ignore_no_extra_done", 64'(done), 64'd0);

    // Back-to-back: start held through the DONE cycle yields a second done with no IDLE gap.
    issue("b2b_first", C_ADD, 32'd2, 32'd3, 64'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_first_done", 64'(done), 64'd1);
    issue("b2b_second", C_ADD, 32'd1, 32'd1, 64'd2, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_done", 64'(done), 64'd1);
    @(negedge clk);
    check("b2b_then_idle", 64'(done), 64'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
